// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator sequencers.
//   state_t  : sequencer state (IDLE / STREAM / DONE), 2-bit, IDLE = 0
//   COORD_W  : width of row/column coordinates and frame dimensions
//   WCOUNT_W : width of the emitted-window counter
//   MIN_DIM  : smallest frame dimension that still holds one 3x3 window
package conv_pkg;

  localparam int COORD_W  = 8;
  localparam int WCOUNT_W = 16;

  localparam logic [COORD_W-1:0] MIN_DIM = 8'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/window_seq_ctrl_raster_counter.sv
// raster_counter: row/column position of the pixel being accepted now.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : return to (0,0) at frame start
//   en             : advance one pixel in raster order
//   width, height  : latched frame dimensions
//   row, col       : coordinate of the current (not yet accepted) pixel
//   last           : current pixel is the final one of the frame
module raster_counter
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);

  logic col_end;

  assign col_end = (col == width - 8'd1);
  assign last    = col_end && (row == height - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        // Wrap the row too on the last pixel so the counter idles at (0,0).
        row <= last ? '0 : row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/window_seq_ctrl.sv
// window_seq_ctrl: raster-scan sequencer for the 3x3 window collector.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : frame start, sampled only in IDLE
//   cfg_width, cfg_height : frame dimensions, latched on start
//   in_valid / in_ready   : upstream pixel handshake
//   win_ready             : downstream MAC can take a window
//   shift_en              : collector advance (the accept strobe)
//   win_valid             : collector taps hold a complete window
//   win_row, win_col      : window centre, meaningful while win_valid
//   win_count             : windows emitted since start (saturating)
//   busy                  : streaming a frame
//   done                  : one-cycle frame-end pulse
//   cfg_err               : last start carried an illegal configuration
module window_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COORD_W-1:0]  cfg_width,
  input  logic [COORD_W-1:0]  cfg_height,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                win_ready,
  output logic                shift_en,
  output logic                win_valid,
  output logic [COORD_W-1:0]  win_row,
  output logic [COORD_W-1:0]  win_col,
  output logic [WCOUNT_W-1:0] win_count,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  // One extra bit so a 128/256-style maximum compares without truncation.
  localparam logic [COORD_W:0] MAX_W = (COORD_W+1)'(IMAGE_WIDTH);
  localparam logic [COORD_W:0] MAX_H = (COORD_W+1)'(IMAGE_HEIGHT);

  state_t             state;
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               last;
  logic               accept;
  logic               start_go;
  logic               cfg_bad;

  assign cfg_bad = (cfg_width < MIN_DIM) || (cfg_height < MIN_DIM) ||
                   ({1'b0, cfg_width} > MAX_W) || ({1'b0, cfg_height} > MAX_H);

  assign start_go = (state == IDLE) && start;

  // Ready follows the MAC directly so a stall freezes the raster in the same cycle.
  assign in_ready = (state == STREAM) && win_ready;
  assign accept   = in_valid && in_ready;
  assign shift_en = accept;

  // The live pixel is collector tap 9, so the window is judged on the accepting
  // beat itself; columns/rows 0-1 would wrap across rows or read stale lines.
  assign win_valid = accept && (row >= 8'd2) && (col >= 8'd2);
  assign win_row   = win_valid ? row - 8'd1 : '0;
  assign win_col   = win_valid ? col - 8'd1 : '0;

  raster_counter u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_go),
    .en     (accept),
    .width  (w_q),
    .height (h_q),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      win_count <= '0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_q       <= cfg_width;
            h_q       <= cfg_height;
            win_count <= '0;
            cfg_err   <= cfg_bad;
            if (cfg_bad) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= STREAM;
              busy  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (win_valid && (win_count != '1)) begin
            win_count <= win_count + 16'd1;
          end
          if (accept && last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Bench for window_seq_ctrl: randomized handshake stimulus checked against a
// pixel-index model (pixel k sits at row k/W, column k%W).
module tb_window_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_width = 8'd0;
  logic [7:0]  cfg_height = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        win_ready = 1'b0;
  logic        shift_en;
  logic        win_valid;
  logic [7:0]  win_row;
  logic [7:0]  win_col;
  logic [15:0] win_count;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  window_seq_ctrl #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_ready  (win_ready),
    .shift_en   (shift_en),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_count  (win_count),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  function automatic logic [37:0] out_vec();
    return {in_ready, shift_en, win_valid, busy, done, cfg_err, win_row, win_col, win_count};
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_vec() !== 38'd0) $display("FAIL reset_async outputs=%h required=0", out_vec());
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_vec() !== 38'd0) $display("FAIL reset_release outputs=%h required=0", out_vec());
    else n_pass++;
    $display("reset: outputs=%h", out_vec());
  endtask

  // Entered at posedge+1 with the DUT in IDLE; leaves at posedge+1 in IDLE.
  task automatic run_frame(input int w, input int h, input int vp, input int rp,
                           input int abort_at, input bit perturb, input string tag);
    int  n_acc   = 0;
    int  exp_cnt = 0;
    int  cyc     = 0;
    int  r, c;
    bit  acc, exp_wv;
    start = 1'b1; cfg_width = 8'(w); cfg_height = 8'(h);
    in_valid = 1'b0; win_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start actual=%b required=1", tag, busy);
    else n_pass++;
    while (n_acc < w * h && cyc < 60000) begin
      in_valid  = (int'($urandom_range(99)) < vp);
      win_ready = (int'($urandom_range(99)) < rp);
      if (perturb) begin
        start      = ($urandom_range(3) == 0);
        cfg_width  = 8'($urandom);
        cfg_height = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && win_ready;
      n_checks++;
      if (in_ready !== win_ready || shift_en !== acc)
        $display("FAIL %s handshake cyc=%0d in_ready=%b shift_en=%b required %b/%b",
                 tag, cyc, in_ready, shift_en, win_ready, acc);
      else n_pass++;
      exp_wv = 1'b0;
      r = n_acc / w;
      c = n_acc % w;
      if (acc) exp_wv = (r >= 2) && (c >= 2);
      n_checks++;
      if (win_valid !== exp_wv)
        $display("FAIL %s win_valid pix=%0d actual=%b required=%b", tag, n_acc, win_valid, exp_wv);
      else n_pass++;
      if (exp_wv) begin
        n_checks++;
        if (win_row !== 8'(r - 1) || win_col !== 8'(c - 1))
          $display("FAIL %s win_coord pix=%0d actual=(%0d,%0d) required=(%0d,%0d)",
                   tag, n_acc, win_row, win_col, r - 1, c - 1);
        else n_pass++;
        if (exp_cnt < 65535) exp_cnt++;
      end
      if (acc) n_acc++;
      if (abort_at != 0 && acc && n_acc == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== 38'd0) $display("FAIL %s abort_async outputs=%h required=0", tag, out_vec());
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_vec() !== 38'd0) $display("FAIL %s abort_held outputs=%h required=0", tag, out_vec());
        else n_pass++;
        rst_n = 1'b1; in_valid = 1'b0; win_ready = 1'b0; start = 1'b0;
        $display("%s: aborted by reset after %0d accepts", tag, n_acc);
        return;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0; win_ready = 1'b0; start = 1'b0;
    n_checks++;
    if (n_acc != w * h) begin
      $display("FAIL %s timeout accepts=%0d required=%0d", tag, n_acc, w * h);
      return;
    end
    n_pass++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL %s frame_end done=%b busy=%b in_ready=%b cfg_err=%b required 1/0/0/0",
               tag, done, busy, in_ready, cfg_err);
    else n_pass++;
    n_checks++;
    if (win_count !== 16'(exp_cnt))
      $display("FAIL %s win_count actual=%0d required=%0d", tag, win_count, exp_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s done_pulse_width done=%b busy=%b required 0/0", tag, done, busy);
    else n_pass++;
    $display("%s: %0dx%0d accepts=%0d cycles=%0d windows=%0d", tag, w, h, n_acc, cyc, win_count);
  endtask

  task automatic test_cfg_err(input int w, input int h);
    start = 1'b1; cfg_width = 8'(w); cfg_height = 8'(h);
    in_valid = 1'b1; win_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || shift_en !== 1'b0)
      $display("FAIL cfg_err_idle_ready in_ready=%b shift_en=%b required 0/0", in_ready, shift_en);
    else n_pass++;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || shift_en !== 1'b0)
      $display("FAIL cfg_err_done done=%b cfg_err=%b busy=%b in_ready=%b shift_en=%b required 1/1/0/0/0",
               done, cfg_err, busy, in_ready, shift_en);
    else n_pass++;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || cfg_err !== 1'b1 || in_ready !== 1'b0 || win_count !== 16'd0)
        $display("FAIL cfg_err_sticky done=%b cfg_err=%b in_ready=%b win_count=%0d required 0/1/0/0",
                 done, cfg_err, in_ready, win_count);
      else n_pass++;
    end
    in_valid = 1'b0; win_ready = 1'b0;
    $display("cfg_err: %0dx%0d cfg_err=%b", w, h, cfg_err);
  endtask

  task automatic test_basic();
    run_frame(5, 4, 100, 100, 0, 1'b0, "basic_5x4");
    n_checks++;
    if (win_count !== 16'd6) $display("FAIL basic_count actual=%0d required=6", win_count);
    else n_pass++;
    run_frame(3, 3, 100, 100, 0, 1'b0, "min_3x3");
    n_checks++;
    if (win_count !== 16'd1) $display("FAIL min_count actual=%0d required=1", win_count);
    else n_pass++;
  endtask

  task automatic test_random_full();
    run_frame(128, 128, 75, 75, 0, 1'b0, "random_128x128");
    n_checks++;
    if (win_count !== 16'd15876) $display("FAIL full_count actual=%0d required=15876", win_count);
    else n_pass++;
  endtask

  task automatic test_perturb();
    run_frame(8, 6, 80, 80, 0, 1'b1, "perturb_8x6");
    n_checks++;
    if (win_count !== 16'd24) $display("FAIL perturb_count actual=%0d required=24", win_count);
    else n_pass++;
  endtask

  task automatic test_abort();
    run_frame(16, 16, 90, 90, 37, 1'b0, "abort_16x16");
    run_frame(16, 16, 85, 85, 0, 1'b0, "fresh_16x16");
    n_checks++;
    if (win_count !== 16'd196) $display("FAIL fresh_count actual=%0d required=196", win_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame(6, 5, 100, 100, 0, 1'b0, "b2b_first_6x5");
    run_frame(4, 3, 100, 100, 0, 1'b0, "b2b_second_4x3");
    n_checks++;
    if (win_count !== 16'd2) $display("FAIL b2b_count actual=%0d required=2", win_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_full();
    test_cfg_err(2, 5);
    test_cfg_err(10, 200);
    test_cfg_err(129, 10);
    test_perturb();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_seq_ctrl.md
# window_seq_ctrl

Raster-scan sequencer for the 3x3 line-buffer window collector in the convolution accelerator. Accepts one pixel per valid/ready beat and tracks the row/column of the newest pixel. Issues the collector shift enable and flags the beats on which the nine collector taps form a legal, non-wrapping window, with its centre coordinate. Sits between the feature-map reader and the collector/MAC array; programmed once per frame by the layer scheduler.

## Interface
- IMAGE_WIDTH, 128, maximum supported frame width (collector line-buffer depth)
- IMAGE_HEIGHT, 128, maximum supported frame height
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame start request, sampled only in IDLE
- cfg_width  in  8  frame width for this stage; drives collector stage_width
- cfg_height  in  8  frame height for this stage
- in_valid  in  1  upstream pixel present
- in_ready  out  1  pixel accepted this cycle when in_valid also high
- win_ready  in  1  downstream MAC can consume a window
- shift_en  out  1  collector advance; equals accept (in_valid & in_ready)
- win_valid  out  1  collector taps form a complete window this cycle
- win_row, win_col  out  8 each  centre coordinate of current window
- win_count  out  16  windows emitted since last start
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  sticky until next start; illegal configuration

## Operation
- States: IDLE, STREAM, DONE. Encoding 2 bits, IDLE = 0.
- IDLE: on start, latch cfg_width/cfg_height (W, H), clear row/col/win_count/cfg_err. If W<3, H<3, W>IMAGE_WIDTH or H>IMAGE_HEIGHT: set cfg_err, go DONE. Otherwise go STREAM.
- STREAM: in_ready = win_ready. accept = in_valid & in_ready.
- Per accept: col increments; at col==W-1, col wraps to 0 and row increments.
- STREAM exit: accept at (H-1, W-1) -> DONE.
- win_valid = accept & row>=2 & col>=2. This is combinational: collector tap 9 is the live pixel.
- win_row = row-1; win_col = col-1.
- win_count increments on win_valid, saturating at 16'hFFFF.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. cfg_* changes outside IDLE are ignored.
- Columns 0 and 1 never produce a window: the taps there wrap across rows.
- Rows 0 and 1 never produce a window: line-buffer contents there are stale.
- A frame of W x H yields exactly (W-2)(H-2) windows.

## Timing
- Reset values: state IDLE, in_ready 0, shift_en 0, win_valid 0, win_row 0, win_col 0, win_count 0, busy 0, done 0, cfg_err 0.
- Reset asserted mid-frame aborts immediately to IDLE. No done pulse.
- start high in IDLE at cycle t: busy and in_ready may be high from t+1.
- Window latency: 0 cycles from the accepting beat. win_row/win_col are valid only while win_valid is high.
- Last accept at cycle t: done high at t+1, busy low at t+1, IDLE at t+2. A start at t+2 is honoured.
- cfg_err path: start at t, done at t+1, no accept ever issued.
- win_ready low stalls all counters; in_valid without ready has no effect.

## Structure
- Shared package conv_pkg holds:
  - state typedef (IDLE/STREAM/DONE)
  - COORD_W = 8, WCOUNT_W = 16
  - MIN_DIM = 3
- One sub-module: raster_counter. Holds the col/row registers with an enable, wrap at the latched W, and last-pixel flag. It is reused by the pooling sequencer.

## Test plan
- 5x4 frame, in_valid and win_ready held high: 20 accepts. Windows at (1,1), (1,2), (1,3), (2,1), (2,2), (2,3). win_count=6, done pulse 1 cycle after accept 20.
- 128x128 with random in_valid gaps and win_ready stalls: win_count=15876, no shift_en while win_ready low, window coordinates monotonic in raster order.
- cfg_width=2, and separately cfg_height=200: cfg_err=1, done 1 cycle after start, zero accepts, in_ready never high.
- start pulsed during STREAM, and cfg changed mid-frame: no effect on counters; frame completes with original W/H.
- rst_n asserted at accept 37 of a 16x16 frame: all outputs return to reset values asynchronously. A fresh 16x16 frame then yields 196 windows.
- Back-to-back frames, start asserted the first cycle after returning to IDLE: second frame accepted, win_count restarts from 0.
